// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state and owner encodings for the memory arbiter
package ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: data-over-fetch priority with an anti-starvation override
module mem_arb_pick (
  input  logic if_req,
  input  logic d_req,
  input  logic starve,
  output logic pick_if,
  output logic pick_d
);
  always_comb begin
    pick_if = if_req && (starve || !d_req);
    pick_d  = d_req && !pick_if;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data, one access at a time
module mem_arbiter
  import ctrl_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam logic [2:0] SMAX = 3'(STARVE_MAX);
  localparam logic [2:0] LAT  = 3'(MEM_LAT);
  arb_state_t  state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic        we_q, we_d;
  logic [2:0]  streak_q, streak_d, lat_q, lat_d;
  logic        pick_if, pick_d, idle;

  mem_arb_pick u_pick (
    .if_req (if_req),
    .d_req  (d_req),
    .starve (streak_q == SMAX),
    .pick_if(pick_if),
    .pick_d (pick_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      streak_q   <= '0;
      lat_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      streak_q   <= streak_d;
      lat_q      <= lat_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    streak_d   = streak_q;
    lat_d      = lat_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      IDLE: if (if_gnt || d_gnt) begin
        state_d  = ACCESS;
        owner_d  = if_gnt ? OWN_IF : OWN_D;
        addr_d   = if_gnt ? if_addr : d_addr;
        wdata_d  = if_gnt ? wdata_q : d_wdata;
        we_d     = d_gnt && d_we;
        // streak only grows while fetch is actually waiting behind data
        streak_d = (d_gnt && if_req) ? ((streak_q == SMAX) ? SMAX : streak_q + 3'd1) : 3'd0;
      end
      ACCESS: begin
        state_d = WAIT;
        lat_d   = LAT;
      end
      WAIT: begin
        lat_d = lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          state_d    = RESP;
          if_rdata_d = (!we_q && owner_q == OWN_IF) ? mem_rdata : if_rdata_q;
          d_rdata_d  = (!we_q && owner_q == OWN_D) ? mem_rdata : d_rdata_q;
        end
      end
      RESP: state_d = IDLE;
    endcase
  end

  always_comb begin
    idle      = state_q == IDLE && !rst;
    if_gnt    = idle && pick_if;
    d_gnt     = idle && pick_d;
    mem_rd    = state_q == ACCESS && !we_q;
    mem_wr    = state_q == ACCESS && we_q;
    if_rvalid = state_q == RESP && owner_q == OWN_IF;
    d_rvalid  = state_q == RESP && owner_q == OWN_D;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning cycles from the mem_rd cycle to valid mem_rdata (legal range 1..7).
REQ-002 SHALL have parameter STARVE_MAX, default 2, meaning the maximum consecutive data grants while a fetch request is pending.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-004 if_req input 1: fetch request; held with stable if_addr until if_gnt.
REQ-005 if_addr input 32: fetch word address.
REQ-006 if_gnt output 1: one-cycle grant pulse to fetch.
REQ-007 if_rvalid output 1, if_rdata output 32: one-cycle fetch read-data-valid pulse, with data.
REQ-008 d_req input 1, d_we input 1, d_addr input 32, d_wdata input 32: data request, write enable, address, write data; all held stable until d_gnt.
REQ-009 d_gnt output 1, d_rvalid output 1, d_rdata output 32: data grant pulse, completion pulse (loads and stores), load data.
REQ-010 mem_rd output 1, mem_wr output 1, mem_addr output 32, mem_wdata output 32: single shared memory port strobes, address and write data.
REQ-011 mem_rdata input 32: memory read data.

Function
REQ-012 The FSM SHALL have four states: IDLE, ACCESS, WAIT, RESP.
REQ-013 IDLE: if any request is present, assert exactly one gnt combinationally, latch owner/addr/we/wdata, go to ACCESS; with no request, stay in IDLE with all strobes 0.
REQ-014 Priority: data wins over fetch, except that fetch wins when if_req=1 and streak==STARVE_MAX.
REQ-015 streak (3-bit): +1 on a data grant while if_req=1; cleared on a fetch grant or on a data grant with if_req=0; saturates at STARVE_MAX.
REQ-016 ACCESS (exactly 1 cycle): mem_addr=latched addr; mem_rd=!we or mem_wr=we, never both; load lat_cnt=MEM_LAT; go to WAIT.
REQ-017 WAIT: lat_cnt decrements each cycle; on the cycle lat_cnt==1, register mem_rdata into the owner's rdata (reads only) and go to RESP.
REQ-018 RESP (1 cycle): assert the owner's rvalid; rdata holds its value until the next read by the same owner; go to IDLE.
REQ-019 Latency: grant in cycle 0, strobe in cycle 1, rvalid in cycle 2+MEM_LAT; the next grant is no earlier than cycle 3+MEM_LAT.
REQ-020 Stores SHALL leave d_rdata unchanged; d_rvalid still pulses as completion.
REQ-021 Requests arriving outside IDLE SHALL be ignored until IDLE; nothing is queued internally.
REQ-022 mem_wdata SHALL equal the latched wdata in ACCESS, and mem_addr/mem_wdata SHALL hold the last latched values otherwise.
REQ-023 if_gnt, d_gnt, if_rvalid, d_rvalid, mem_rd and mem_wr SHALL never be high in two consecutive cycles.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE regardless of the current state, dropping any in-flight access without an rvalid.
REQ-025 Reset values SHALL be 0 for: streak, lat_cnt, owner, latched addr/wdata/we, if_rdata, d_rdata and all strobes/pulses.
REQ-026 Grant logic SHALL be masked while rst=1, so no gnt is issued in a reset cycle.

Structure
REQ-027 Shared package ctrl_pkg SHALL hold the arb_state_t enum (IDLE, ACCESS, WAIT, RESP) and the owner_t enum (OWN_IF, OWN_D).
REQ-028 A combinational sub-module mem_arb_pick SHALL compute the grant (inputs: if_req, d_req, streak==STARVE_MAX); the FSM, counters and latches stay in mem_arbiter.

Verification (MEM_LAT=1, STARVE_MAX=2 unless stated)
REQ-029 Fetch only: if_req with addr 0x00000010, memory returns 0x00A00093 -> if_gnt cycle 0; mem_rd=1 with mem_addr=0x10 in cycle 1; if_rvalid=1 with if_rdata=0x00A00093 in cycle 3.
REQ-030 Simultaneous if_req (0x14) and load d_req (0x100) -> d_gnt first with mem_addr=0x100; if_gnt at the next IDLE; memory addresses in order 0x100, 0x14.
REQ-031 Starvation: d_req and if_req both held continuously -> grant order D, D, IF, D, D, IF.
REQ-032 Store: d_we=1, addr 0x20, wdata 0xDEADBEEF -> mem_wr one cycle with mem_wdata=0xDEADBEEF and mem_rd=0; d_rvalid pulses; d_rdata unchanged.
REQ-033 Reset during WAIT -> IDLE next cycle; no rvalid; strobes 0; streak 0; a subsequent fetch behaves as in REQ-029.
REQ-034 MEM_LAT=3, fetch 0x40 -> mem_rd in cycle 1 and if_rvalid in cycle 5, with if_rdata captured from mem_rdata in cycle 4.
